pia_scan_ctrl: RTL and testbench

PIA_SCAN_CTRL -- requirements
Module: pia_scan_ctrl

---
 rtl/pia_scan_ctrl_pkg.sv | 41 ++++
 rtl/pia_scan_ctrl_debounce.sv | 72 +++++++
 rtl/pia_scan_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pia_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pia_scan_ctrl_pkg.sv
// Shared types and constants for the PIA keyboard scanner.
// FSM states, PIA register map and row-decode helper.
package pia_scan_ctrl_pkg;

    typedef enum logic [3:0] {
        S_OFF,
        S_I_CRA0,
        S_I_DDRA,
        S_I_CRA4,
        S_I_CRB0,
        S_I_DDRB,
        S_I_CRB4,
        S_WAIT,
        S_DRIVE,
        S_SETTLE,
        S_READ,
        S_CAPT,
        S_EVAL
    } scan_state_t;

    localparam logic [1:0] PIA_ORA  = 2'd0;
    localparam logic [1:0] PIA_DDRA = 2'd0;
    localparam logic [1:0] PIA_CRA  = 2'd1;
    localparam logic [1:0] PIA_ORB  = 2'd2;
    localparam logic [1:0] PIA_DDRB = 2'd2;
    localparam logic [1:0] PIA_CRB  = 2'd3;
    localparam logic [7:0] CR_ORSEL = 8'h04;

    localparam int KEY_W = 6;

    // {found, index} of the lowest zero bit; rows are active low
    function automatic logic [3:0] low_zero(input logic [7:0] v);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!v[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/pia_scan_ctrl_debounce.sv
// Frame-to-frame key debouncer and key report register.
// One report per press; a no-hit frame re-arms the report latch.
module scan_debounce
    import pia_scan_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             eval,
    input  logic             hit,
    input  logic [KEY_W-1:0] code,
    input  logic             key_ack,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             overrun
);

    localparam logic [7:0] DB_MAX = 8'(DEBOUNCE);

    logic [7:0]       stable;
    logic [7:0]       stable_nx;
    logic [KEY_W-1:0] prev;
    logic             latch;
    logic             qual;

    // next stable count and qualification for the frame being closed
    always_comb begin
        stable_nx = 8'd0;
        if (hit) begin
            if (stable != 8'd0 && code == prev)
                stable_nx = (stable >= DB_MAX) ? DB_MAX : stable + 8'd1;
            else
                stable_nx = 8'd1;
        end
        qual = eval && hit && (stable_nx == DB_MAX) && !latch;
    end

    // debounce state and the consumer-facing key register
    always_ff @(posedge clk) begin
        if (!reset) begin
            stable    <= 8'd0;
            prev      <= '0;
            latch     <= 1'b0;
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (eval) begin
                stable <= stable_nx;
                prev   <= code;
                if (!hit)
                    latch <= 1'b0;
                else if (qual)
                    latch <= 1'b1;
            end
            if (key_ack) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
            if (qual) begin
                if (!key_valid || key_ack) begin
                    key_code  <= code;
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pia_scan_ctrl.sv
// 8x8 keyboard scanner sharing a PIA register port with a CPU.
// CPU always wins the port; a stalled scanner cycle repeats unchanged.
module pia_scan_ctrl
    import pia_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_en,
    input  logic             cpu_cs,
    input  logic             cpu_rw,
    input  logic [1:0]       cpu_addr,
    input  logic [7:0]       cpu_dataIn,
    output logic             pia_cs,
    output logic             pia_rw,
    output logic [1:0]       pia_addr,
    output logic [7:0]       pia_dataIn,
    input  logic [7:0]       pia_dataOut,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ack,
    output logic             overrun
);

    scan_state_t      state;
    scan_state_t      state_nx;
    logic [15:0]      cnt;
    logic [2:0]       col;
    logic             hit;
    logic [KEY_W-1:0] cand;
    logic             scan_en_q;
    logic             s_cs;
    logic             s_rw;
    logic [1:0]       s_addr;
    logic [7:0]       s_data;
    logic             adv;
    logic             div_done;
    logic             set_done;
    logic             eval;
    logic [3:0]       rz;

    assign adv      = !cpu_cs;
    assign div_done = (cnt == 16'(SCAN_DIV - 1));
    assign set_done = (cnt == 16'(SETTLE - 1));
    assign rz       = low_zero(pia_dataOut);
    assign eval     = (state == S_EVAL) && adv && scan_en;

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_OFF;
        else        state <= state_nx;
    end

    // next state and the scanner's bus request for this clock
    always_comb begin
        state_nx = state;
        s_cs     = 1'b0;
        s_rw     = 1'b1;
        s_addr   = 2'd0;
        s_data   = 8'h00;
        unique case (state)
            S_OFF: begin
                if (scan_en && !scan_en_q) state_nx = S_I_CRA0;
            end
            S_I_CRA0: begin
                s_cs = 1'b1; s_rw = 1'b0;
                s_addr = PIA_CRA; s_data = 8'h00;
                if (adv) state_nx = S_I_DDRA;
            end
            S_I_DDRA: begin
                s_cs = 1'b1; s_rw = 1'b0;
                s_addr = PIA_DDRA; s_data = 8'hFF;
                if (adv) state_nx = S_I_CRA4;
            end
            S_I_CRA4: begin
                s_cs = 1'b1; s_rw = 1'b0;
                s_addr = PIA_CRA; s_data = CR_ORSEL;
                if (adv) state_nx = S_I_CRB0;
            end
            S_I_CRB0: begin
                s_cs = 1'b1; s_rw = 1'b0;
                s_addr = PIA_CRB; s_data = 8'h00;
                if (adv) state_nx = S_I_DDRB;
            end
            S_I_DDRB: begin
                s_cs = 1'b1; s_rw = 1'b0;
                s_addr = PIA_DDRB; s_data = 8'h00;
                if (adv) state_nx = S_I_CRB4;
            end
            S_I_CRB4: begin
                s_cs = 1'b1; s_rw = 1'b0;
                s_addr = PIA_CRB; s_data = CR_ORSEL;
                if (adv) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (adv && div_done) state_nx = S_DRIVE;
            end
            S_DRIVE: begin
                s_cs = 1'b1; s_rw = 1'b0;
                s_addr = PIA_ORA; s_data = ~(8'd1 << col);
                if (adv) state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                if (adv && set_done) state_nx = S_READ;
            end
            S_READ: begin
                s_cs = 1'b1; s_rw = 1'b1;
                s_addr = PIA_ORB;
                if (adv) state_nx = S_CAPT;
            end
            S_CAPT: begin
                state_nx = (col == 3'd7) ? S_EVAL : S_WAIT;
            end
            S_EVAL: begin
                if (adv) state_nx = S_WAIT;
            end
            default: state_nx = S_OFF;
        endcase
        if (!scan_en) state_nx = S_OFF;
    end

    // column, delay counter and per-frame candidate tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= 16'd0;
            col       <= 3'd0;
            hit       <= 1'b0;
            cand      <= '0;
            scan_en_q <= 1'b0;
        end else begin
            scan_en_q <= scan_en;
            if (!scan_en) begin
                cnt <= 16'd0;
                col <= 3'd0;
                hit <= 1'b0;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (adv) cnt <= div_done ? 16'd0 : cnt + 16'd1;
                    end
                    S_SETTLE: begin
                        if (adv) cnt <= set_done ? 16'd0 : cnt + 16'd1;
                    end
                    S_CAPT: begin
                        if (!hit && rz[3]) begin
                            hit  <= 1'b1;
                            cand <= {col, rz[2:0]};
                        end
                        if (col != 3'd7) col <= col + 3'd1;
                    end
                    S_EVAL: begin
                        if (adv) begin
                            col <= 3'd0;
                            hit <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // port mux: CPU first, then scanner, else idle read
    always_comb begin
        pia_cs     = 1'b0;
        pia_rw     = 1'b1;
        pia_addr   = 2'd0;
        pia_dataIn = 8'h00;
        if (cpu_cs) begin
            pia_cs     = 1'b1;
            pia_rw     = cpu_rw;
            pia_addr   = cpu_addr;
            pia_dataIn = cpu_dataIn;
        end else if (reset && s_cs) begin
            pia_cs     = 1'b1;
            pia_rw     = s_rw;
            pia_addr   = s_addr;
            pia_dataIn = s_data;
        end
    end

    scan_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .eval      (eval),
        .hit       (hit),
        .code      (cand),
        .key_ack   (key_ack),
        .key_code  (key_code),
        .key_valid (key_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_pia_scan_ctrl.sv
// Directed bench for pia_scan_ctrl with a behavioural PIA/keypad.
// SCAN_DIV=4, SETTLE=2, DEBOUNCE=3: 9 clocks per column, 73 per frame.
module tb_pia_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_en;
    logic       cpu_cs;
    logic       cpu_rw;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_dataIn;
    logic       pia_cs;
    logic       pia_rw;
    logic [1:0] pia_addr;
    logic [7:0] pia_dataIn;
    logic [7:0] pia_dataOut = 8'hFF;
    logic [5:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       overrun;

    logic [7:0] keys [8];
    logic [7:0] porta = 8'hFF;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       cs;
        logic       rw;
        logic [1:0] a;
        logic [7:0] d;
        logic [11:0] exp;
    } arb_t;

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
    } wr_t;

    arb_t arb_tab [5];
    wr_t  init_tab [6];

    always #5 clk = ~clk;

    pia_scan_ctrl #(
        .SCAN_DIV (4),
        .SETTLE   (2),
        .DEBOUNCE (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_en     (scan_en),
        .cpu_cs      (cpu_cs),
        .cpu_rw      (cpu_rw),
        .cpu_addr    (cpu_addr),
        .cpu_dataIn  (cpu_dataIn),
        .pia_cs      (pia_cs),
        .pia_rw      (pia_rw),
        .pia_addr    (pia_addr),
        .pia_dataIn  (pia_dataIn),
        .pia_dataOut (pia_dataOut),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ack     (key_ack),
        .overrun     (overrun)
    );

    function automatic logic [7:0] rows_of(input logic [7:0] pa);
        logic [7:0] r;
        r = 8'hFF;
        for (int c = 0; c < 8; c++)
            if (!pa[c]) r = r & ~keys[c];
        return r;
    endfunction

    // keypad behind the PIA: port A drives columns, port B reads rows
    always @(posedge clk) begin
        if (pia_cs && !pia_rw && pia_addr == 2'd0)
            porta <= pia_dataIn;
        if (pia_cs && pia_rw && pia_addr == 2'd2)
            pia_dataOut <= rows_of(porta);
    end

    function automatic logic [31:0] bus_now();
        return 32'({pia_cs, pia_rw, pia_addr, pia_dataIn});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic check_init();
        for (int i = 0; i < 6; i++) begin
            clk1();
            chk($sformatf("init%0d", i), bus_now(),
                32'({1'b1, 1'b0, init_tab[i].a, init_tab[i].d}));
        end
        clk1();
        chk("wait_idle", 32'({pia_cs, pia_rw}), 32'(2'b01));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 400) begin
            clk1();
            n++;
            if (key_valid) break;
        end
    endtask

    initial begin
        int n;
        int rep;
        logic [7:0] d;

        reset      = 1'b0;
        scan_en    = 1'b0;
        cpu_cs     = 1'b0;
        cpu_rw     = 1'b1;
        cpu_addr   = 2'd0;
        cpu_dataIn = 8'h00;
        key_ack    = 1'b0;
        for (int c = 0; c < 8; c++) keys[c] = 8'h00;

        arb_tab[0] = '{1'b1, 1'b0, 2'd1, 8'h00, 12'b1_0_01_00000000};
        arb_tab[1] = '{1'b1, 1'b1, 2'd3, 8'hA5, 12'b1_1_11_10100101};
        arb_tab[2] = '{1'b1, 1'b0, 2'd2, 8'hFF, 12'b1_0_10_11111111};
        arb_tab[3] = '{1'b0, 1'b0, 2'd3, 8'h3C, 12'b0_1_00_00000000};
        arb_tab[4] = '{1'b0, 1'b1, 2'd1, 8'h81, 12'b0_1_00_00000000};

        init_tab[0] = '{2'd1, 8'h00};
        init_tab[1] = '{2'd0, 8'hFF};
        init_tab[2] = '{2'd1, 8'h04};
        init_tab[3] = '{2'd3, 8'h00};
        init_tab[4] = '{2'd2, 8'h00};
        init_tab[5] = '{2'd3, 8'h04};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(key_valid), 32'(0));
        chk("rst_code", 32'(key_code), 32'(0));
        chk("rst_ovr", 32'(overrun), 32'(0));
        chk("rst_bus", bus_now(), 32'(12'b0_1_00_00000000));

        reset = 1'b1;
        clk1();
        for (int i = 0; i < 5; i++) begin
            cpu_cs     = arb_tab[i].cs;
            cpu_rw     = arb_tab[i].rw;
            cpu_addr   = arb_tab[i].a;
            cpu_dataIn = arb_tab[i].d;
            #1;
            chk($sformatf("arb%0d", i), bus_now(), 32'(arb_tab[i].exp));
            clk1();
        end
        cpu_cs = 1'b0;
        clk1();

        keys[3] = 8'h20;
        scan_en = 1'b1;
        check_init();
        wait_valid(n);
        chk("qual_latency", 32'(n), 32'(219));
        chk("key1_valid", 32'(key_valid), 32'(1));
        chk("key1_code", 32'(key_code), 32'(6'h1D));

        key_ack = 1'b1;
        clk1();
        key_ack = 1'b0;
        chk("ack_clear", 32'(key_valid), 32'(0));
        rep = 0;
        repeat (250) begin
            clk1();
            if (key_valid) rep++;
        end
        chk("held_no_rerep", 32'(rep), 32'(0));
        chk("held_no_ovr", 32'(overrun), 32'(0));

        keys[3] = 8'h00;
        repeat (160) clk1();
        keys[2] = 8'h40;
        keys[5] = 8'h02;
        wait_valid(n);
        chk("two_valid", 32'(key_valid), 32'(1));
        chk("two_code", 32'(key_code), 32'(6'h16));
        chk("two_ovr", 32'(overrun), 32'(0));

        keys[2] = 8'h00;
        keys[5] = 8'h00;
        repeat (160) clk1();
        keys[3] = 8'h20;
        n = 0;
        while (n < 400 && !overrun) begin
            clk1();
            n++;
        end
        chk("ovr_set", 32'(overrun), 32'(1));
        chk("ovr_code_kept", 32'(key_code), 32'(6'h16));
        chk("ovr_valid", 32'(key_valid), 32'(1));
        key_ack = 1'b1;
        clk1();
        key_ack = 1'b0;
        chk("ovr_ack_valid", 32'(key_valid), 32'(0));
        chk("ovr_ack_ovr", 32'(overrun), 32'(0));

        n = 0;
        while (n < 100) begin
            clk1();
            n++;
            if (pia_cs && !pia_rw && pia_addr == 2'd0) break;
        end
        chk("drive_found", 32'(pia_cs && !pia_rw && pia_addr == 2'd0),
            32'(1));
        d = pia_dataIn;
        chk("drive_onehot", 32'($countones(~d)), 32'(1));
        cpu_cs     = 1'b1;
        cpu_rw     = 1'b1;
        cpu_addr   = 2'd1;
        cpu_dataIn = 8'h5A;
        #1;
        chk("stall_cpu", bus_now(), 32'(12'b1_1_01_01011010));
        clk1();
        cpu_cs = 1'b0;
        #1;
        chk("drive_retry", bus_now(), 32'({1'b1, 1'b0, 2'd0, d}));
        clk1();
        chk("settle_idle", 32'(pia_cs), 32'(0));

        reset = 1'b0;
        clk1();
        chk("mid_rst_valid", 32'(key_valid), 32'(0));
        chk("mid_rst_code", 32'(key_code), 32'(0));
        chk("mid_rst_ovr", 32'(overrun), 32'(0));
        chk("mid_rst_bus", bus_now(), 32'(12'b0_1_00_00000000));
        reset = 1'b1;
        check_init();
        wait_valid(n);
        chk("rerun_latency", 32'(n), 32'(219));
        chk("rerun_code", 32'(key_code), 32'(6'h1D));

        scan_en = 1'b0;
        clk1();
        rep = 0;
        repeat (100) begin
            clk1();
            if (pia_cs) rep++;
        end
        chk("off_no_bus", 32'(rep), 32'(0));
        chk("off_valid_kept", 32'(key_valid), 32'(1));
        chk("off_code_kept", 32'(key_code), 32'(6'h1D));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
